// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-stage bus between the PC sequencer and the core: instruction fetch,
// decoder control inputs and the sequencer's status/address outputs.
interface pc_fetch_ctrl_if #(
    parameter int unsigned PC_W = 10
) ();
    logic [31:0]     instr;
    logic            HLT;
    logic            onskip;
    logic            onop;
    logic            endPCorReg;
    logic            onWriteReg;
    logic            cond_true;
    logic [31:0]     reg_target;
    logic            in_confirm;

    logic [PC_W-1:0] imem_addr;
    logic [5:0]      opcode;
    logic [PC_W-1:0] pc_plus1;
    logic            reg_write_en;
    logic            stall;
    logic            halted;
    logic [31:0]     instr_count;

    // Core side: supplies the instruction and decoder results
    modport master (
        output instr, HLT, onskip, onop, endPCorReg, onWriteReg,
               cond_true, reg_target, in_confirm,
        input  imem_addr, opcode, pc_plus1, reg_write_en, stall,
               halted, instr_count
    );

    // Sequencer side
    modport slave (
        input  instr, HLT, onskip, onop, endPCorReg, onWriteReg,
               cond_true, reg_target, in_confirm,
        output imem_addr, opcode, pc_plus1, reg_write_en, stall,
               halted, instr_count
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program counter and fetch sequencer for a single-cycle core: next-PC
// selection, IN-instruction operator stall and permanent HLT freeze.
module pc_fetch_ctrl #(
    parameter int unsigned     PC_W     = 10,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [5:0]      OP_IN    = 6'b010100
) (
    input  logic           clock,
    input  logic           reset,
    pc_fetch_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        WAIT_IN = 2'd1,
        HALTED  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [31:0]     count_q, count_d;
    logic            confirm_q;

    logic [5:0]      opcode_c;
    logic            is_in_c;
    logic            take_c;
    logic            confirm_edge_c;
    logic [PC_W-1:0] target_c;
    logic [PC_W-1:0] pc_inc_c;
    logic            we_c;
    logic            unused_bits;

    // Instruction decode helpers
    assign opcode_c       = bus.instr[31:26];
    assign is_in_c        = (opcode_c == OP_IN);
    assign take_c         = bus.onskip & (~bus.onop | bus.cond_true);
    assign confirm_edge_c = bus.in_confirm & ~confirm_q;
    assign pc_inc_c       = pc_q + PC_W'(1);
    assign target_c       = bus.endPCorReg ? bus.reg_target[PC_W-1:0]
                                           : bus.instr[PC_W-1:0];

    // Only the opcode and low address bits are consumed
    assign unused_bits = ^{bus.instr, bus.reg_target};

    // Next-state, next-PC, retire count and register write gating
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        we_c    = 1'b0;
        case (state_q)
            RUN: begin
                we_c = bus.onWriteReg & ~is_in_c & ~bus.HLT;
                if (bus.HLT) begin
                    state_d = HALTED;
                    count_d = count_q + 32'd1;
                end else if (is_in_c) begin
                    state_d = WAIT_IN;
                end else if (take_c) begin
                    pc_d    = target_c;
                    count_d = count_q + 32'd1;
                end else begin
                    pc_d    = pc_inc_c;
                    count_d = count_q + 32'd1;
                end
            end
            WAIT_IN: begin
                we_c = bus.onWriteReg & confirm_edge_c;
                if (confirm_edge_c) begin
                    state_d = RUN;
                    pc_d    = pc_inc_c;
                    count_d = count_q + 32'd1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = HALTED;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RUN;
            pc_q      <= RESET_PC;
            count_q   <= 32'd0;
            confirm_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            count_q   <= count_d;
            confirm_q <= bus.in_confirm;
        end
    end

    // A reset cycle never commits a register write
    assign bus.imem_addr    = pc_q;
    assign bus.opcode       = opcode_c;
    assign bus.pc_plus1     = pc_inc_c;
    assign bus.reg_write_en = we_c & ~reset;
    assign bus.stall        = (state_q == WAIT_IN);
    assign bus.halted       = (state_q == HALTED);
    assign bus.instr_count  = count_q;

endmodule
